// File: rtl/quad_tach_gen_pkg.sv
// quad_tach_gen_pkg: quadrature phase encodings and Gray-code step sequencing.
package quad_tach_gen_pkg;
  localparam int PERW = 16;
  localparam int POSW = 16;
  typedef enum logic [1:0] {
    PH_S00 = 2'b00,
    PH_S01 = 2'b01,
    PH_S11 = 2'b11,
    PH_S10 = 2'b10
  } phase_t;
  function automatic phase_t next_phase(input phase_t p, input logic fwd);
    case (p)
      PH_S00:  return fwd ? PH_S01 : PH_S10;
      PH_S01:  return fwd ? PH_S11 : PH_S00;
      PH_S11:  return fwd ? PH_S10 : PH_S01;
      default: return fwd ? PH_S00 : PH_S11;
    endcase
  endfunction
endpackage

// File: rtl/quad_tach_gen_if.sv
// quad_tach_gen_if: control, period-write and tach/position readout signals of the tach generator.
interface quad_tach_gen_if;
  logic       ratece;
  logic [7:0] wrtdata;
  logic       perlce;
  logic       perhce;
  logic       enable;
  logic       dir;
  logic       invphase;
  logic       freeze;
  logic [1:0] tach;
  logic       step;
  logic [7:0] countl;
  logic [7:0] counth;
  modport master (
    output ratece, wrtdata, perlce, perhce, enable, dir, invphase, freeze,
    input  tach, step, countl, counth
  );
  modport slave (
    input  ratece, wrtdata, perlce, perhce, enable, dir, invphase, freeze,
    output tach, step, countl, counth
  );
endinterface

// File: rtl/quad_tach_gen_tach_rate_divider.sv
// tach_rate_divider: counts ratece ticks and fires one step every 'active' ticks while running.
module tach_rate_divider #(
  parameter int PERW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ratece,
  input  logic            enable,
  input  logic [PERW-1:0] active,
  output logic            fire
);
  logic [PERW-1:0] div;
  logic            run;
  assign run  = enable && (active != '0);
  assign fire = run && ratece && (div == active - PERW'(1));
  // Divider clears when stopped so a re-enable always runs a full period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div <= '0;
    else if (!run || fire) div <= '0;
    else if (ratece) div <= div + PERW'(1);
  end
endmodule

// File: rtl/quad_tach_gen.sv
// quad_tach_gen: quadrature A/B tach emitter with programmable step period and frozen position readout.
module quad_tach_gen
  import quad_tach_gen_pkg::*;
#(
  parameter int PERW = quad_tach_gen_pkg::PERW,
  parameter int POSW = quad_tach_gen_pkg::POSW
) (
  input  logic            clk,
  input  logic            resetn,
  quad_tach_gen_if.slave  bus
);
  logic [7:0]      lo;
  logic [PERW-1:0] pending;
  logic [PERW-1:0] active;
  logic            fire;
  phase_t          phase;
  logic [1:0]      ph;
  logic            step;
  logic [POSW-1:0] pos;
  logic [POSW-1:0] pos_nxt;
  logic [15:0]     count;
  tach_rate_divider #(.PERW(PERW)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .ratece (bus.ratece),
    .enable (bus.enable),
    .active (active),
    .fire   (fire)
  );
  assign pos_nxt = fire ? (bus.dir ? pos + POSW'(1) : pos - POSW'(1)) : pos;
  // Period staging: the high write uses the low shadow as it stood before this clk; active only
  // changes on a step boundary (or when idle) so a running period is never cut short.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo      <= '0;
      pending <= '0;
      active  <= '0;
    end else begin
      if (bus.perlce) lo <= bus.wrtdata;
      if (bus.perhce) pending <= PERW'({bus.wrtdata, lo});
      if (fire || active == '0) active <= pending;
    end
  end
  // Phase FSM, step pulse and position count all advance on the edge that fires the step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= PH_S00;
      step  <= 1'b0;
      pos   <= '0;
      count <= '0;
    end else begin
      step <= fire;
      if (fire) phase <= next_phase(phase, bus.dir);
      pos <= pos_nxt;
      if (!bus.freeze) count <= 16'(pos_nxt);
    end
  end
  assign ph         = phase;
  assign bus.tach   = bus.invphase ? {ph[0], ph[1]} : ph;
  assign bus.step   = step;
  assign bus.countl = count[7:0];
  assign bus.counth = count[15:8];
endmodule
